// File: rtl/register_file.sv
// Processor register file: NREG x BW storage, two combinational read ports with
// write-through bypass, one synchronous write port, and a 3-bit ALU status register.
module register_file #(
  parameter  int BW   = 16,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_a_addr,
  output logic [BW-1:0] rd_a_data,
  input  logic [AW-1:0] rd_b_addr,
  output logic [BW-1:0] rd_b_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_data,
  input  logic          flags_en,
  input  logic [2:0]    flags_in,
  output logic [2:0]    flags_out
);

  logic [BW-1:0] r_regs [NREG];
  logic [2:0]    r_flags;
  logic          w_hit_a;
  logic          w_hit_b;
  logic [BW-1:0] w_rd_a;
  logic [BW-1:0] w_rd_b;

  // Register storage; reset drops any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end else begin
      r_regs[wr_addr] <= r_regs[wr_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 3'b000;
    end else if (flags_en) begin
      r_flags <= flags_in;
    end else begin
      r_flags <= r_flags;
    end
  end

  // Bypass select compares addresses only, keeping the mux control off the data path.
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_rd_a  = r_regs[rd_a_addr];
    w_rd_b  = r_regs[rd_b_addr];
    if (wr_en && (rd_a_addr == wr_addr)) begin
      w_hit_a = 1'b1;
      w_rd_a  = wr_data;
    end else begin
      w_hit_a = 1'b0;
    end
    if (wr_en && (rd_b_addr == wr_addr)) begin
      w_hit_b = 1'b1;
      w_rd_b  = wr_data;
    end else begin
      w_hit_b = 1'b0;
    end
  end

  assign rd_a_data = w_rd_a;
  assign rd_b_data = w_rd_b;
  assign flags_out = r_flags;

endmodule
